// File: rtl/ace_ack_ctrl_pkg.sv
// Shared types for the ACE completion controller: request/response
// structs for the master-side ACE port.
package ace_ack_ctrl_pkg;

  localparam int unsigned IdWidth   = 4;
  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;

  typedef logic [IdWidth-1:0]       id_t;
  typedef logic [AddrWidth-1:0]     addr_t;
  typedef logic [DataWidth-1:0]     data_t;
  typedef logic [DataWidth/8-1:0]   strb_t;

  typedef struct packed {
    id_t        aw_id;
    addr_t      aw_addr;
    logic [7:0] aw_len;
    logic [5:0] aw_atop;
    logic       aw_valid;
    data_t      w_data;
    strb_t      w_strb;
    logic       w_last;
    logic       w_valid;
    logic       b_ready;
    id_t        ar_id;
    addr_t      ar_addr;
    logic [7:0] ar_len;
    logic       ar_valid;
    logic       r_ready;
    logic       wack;
    logic       rack;
  } ace_req_t;

  typedef struct packed {
    logic       aw_ready;
    logic       ar_ready;
    logic       w_ready;
    id_t        b_id;
    logic [1:0] b_resp;
    logic       b_valid;
    id_t        r_id;
    data_t      r_data;
    logic [3:0] r_resp;
    logic       r_last;
    logic       r_valid;
  } ace_resp_t;

endpackage

// File: rtl/ace_ack_ctrl_if.sv
// ACE request/response bundle. The master modport drives requests,
// the slave modport drives responses.
interface ace_ack_ctrl_if;
  import ace_ack_ctrl_pkg::*;

  ace_req_t  req;
  ace_resp_t resp;

  modport master (output req, input resp);
  modport slave  (input req, output resp);

endinterface

// File: rtl/ace_ack_counter.sv
// One direction (read or write) of the completion controller: counts
// transactions from address handshake to acknowledge, queues acks owed
// after the final data/response handshake, and gates the address
// channel when the limit is reached or the port is draining.
module ace_ack_counter #(
  parameter int unsigned Max  = 8,
  parameter int unsigned CntW = $clog2(Max + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            run_i,
  input  logic            slv_valid_i,
  input  logic            mst_ready_i,
  input  logic            done_i,
  input  logic            hold_i,
  output logic            mst_valid_o,
  output logic            slv_ready_o,
  output logic            ack_o,
  output logic [CntW-1:0] cnt_o,
  output logic            idle_next_o
);

  logic [CntW-1:0] cnt_q, cnt_d, pend_q, pend_d;
  logic            presented_q, presented_d;
  logic            stall, pass, hs;

  // Gating, ack generation and next-state counts; an address already
  // shown on the bus bypasses the gate so its valid stays up until accepted.
  always_comb begin
    stall       = (cnt_q == CntW'(Max)) || !run_i;
    pass        = !stall || presented_q;
    mst_valid_o = slv_valid_i && pass;
    slv_ready_o = mst_ready_i && pass;
    hs          = mst_valid_o && mst_ready_i;
    ack_o       = (pend_q != '0) && !hold_i;
    cnt_d       = cnt_q + CntW'(hs) - CntW'(ack_o);
    pend_d      = pend_q + CntW'(done_i) - CntW'(ack_o);
    presented_d = mst_valid_o && !mst_ready_i;
    idle_next_o = (cnt_d == '0) && !presented_d;
  end

  // Counter and presented-flag registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q       <= '0;
      pend_q      <= '0;
      presented_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      presented_q <= presented_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ace_ack_ctrl.sv
// Master-side ACE completion controller: passes all channels through,
// generates RACK/WACK, limits outstanding reads/writes and offers a
// flush handshake that quiesces the port.
module ace_ack_ctrl
  import ace_ack_ctrl_pkg::*;
#(
  parameter  int unsigned MaxReadTxns  = 8,
  parameter  int unsigned MaxWriteTxns = 8,
  localparam int unsigned RdCntW       = $clog2(MaxReadTxns + 1),
  localparam int unsigned WrCntW       = $clog2(MaxWriteTxns + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  ace_ack_ctrl_if.slave     slv,
  ace_ack_ctrl_if.master    mst,
  input  logic              rack_hold_i,
  input  logic              wack_hold_i,
  input  logic              flush_i,
  output logic              flush_done_o,
  output logic [RdCntW-1:0] rd_outstanding_o,
  output logic [WrCntW-1:0] wr_outstanding_o
);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} ack_ctrl_state_e;

  ack_ctrl_state_e state_q;
  logic            flush_done_q;
  logic            run;
  logic            rd_done, wr_done;
  logic            rd_valid, rd_ready, rd_ack, rd_idle;
  logic            wr_valid, wr_ready, wr_ack, wr_idle;

  assign run     = (state_q == RUN);
  assign rd_done = mst.resp.r_valid && slv.req.r_ready && mst.resp.r_last;
  assign wr_done = mst.resp.b_valid && slv.req.b_ready;

  ace_ack_counter #(.Max(MaxReadTxns), .CntW(RdCntW)) i_rd_cnt (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .run_i       (run),
    .slv_valid_i (slv.req.ar_valid),
    .mst_ready_i (mst.resp.ar_ready),
    .done_i      (rd_done),
    .hold_i      (rack_hold_i),
    .mst_valid_o (rd_valid),
    .slv_ready_o (rd_ready),
    .ack_o       (rd_ack),
    .cnt_o       (rd_outstanding_o),
    .idle_next_o (rd_idle)
  );

  ace_ack_counter #(.Max(MaxWriteTxns), .CntW(WrCntW)) i_wr_cnt (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .run_i       (run),
    .slv_valid_i (slv.req.aw_valid),
    .mst_ready_i (mst.resp.aw_ready),
    .done_i      (wr_done),
    .hold_i      (wack_hold_i),
    .mst_valid_o (wr_valid),
    .slv_ready_o (wr_ready),
    .ack_o       (wr_ack),
    .cnt_o       (wr_outstanding_o),
    .idle_next_o (wr_idle)
  );

  // Request path: pass through, with gated address valids and our own acks.
  always_comb begin
    mst.req          = slv.req;
    mst.req.ar_valid = rd_valid;
    mst.req.aw_valid = wr_valid;
    mst.req.rack     = rd_ack;
    mst.req.wack     = wr_ack;
  end

  // Response path: pass through, with gated address readies.
  always_comb begin
    slv.resp          = mst.resp;
    slv.resp.ar_ready = rd_ready;
    slv.resp.aw_ready = wr_ready;
  end

  // Flush FSM; DONE is entered on the edge where the last ack retires.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= RUN;
      flush_done_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (flush_i) state_q <= DRAIN;
        end
        DRAIN: begin
          if (!flush_i) begin
            state_q <= RUN;
          end else if (rd_idle && wr_idle) begin
            state_q      <= DONE;
            flush_done_q <= 1'b1;
          end
        end
        DONE: begin
          if (!flush_i) begin
            state_q      <= RUN;
            flush_done_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= RUN;
          flush_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign flush_done_o = flush_done_q;

`ifndef SYNTHESIS
  atop_unsupported: assert property (@(posedge clk_i) disable iff (rst_i)
    slv.req.aw_valid |-> (slv.req.aw_atop == '0));
`endif

endmodule

// File: tb/tb_ace_ack_ctrl.sv
// Self-checking bench for ace_ack_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a transaction-count model.
module tb_ace_ack_ctrl;
  import ace_ack_ctrl_pkg::*;

  localparam int unsigned MaxRd = 2;
  localparam int unsigned MaxWr = 3;

  logic clk = 1'b0;
  logic rst;
  logic rack_hold, wack_hold, flush;
  logic flush_done;
  logic [1:0] rd_outstanding;
  logic [1:0] wr_outstanding;

  ace_ack_ctrl_if slv_if ();
  ace_ack_ctrl_if mst_if ();

  ace_ack_ctrl #(.MaxReadTxns(MaxRd), .MaxWriteTxns(MaxWr)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .slv              (slv_if),
    .mst              (mst_if),
    .rack_hold_i      (rack_hold),
    .wack_hold_i      (wack_hold),
    .flush_i          (flush),
    .flush_done_o     (flush_done),
    .rd_outstanding_o (rd_outstanding),
    .wr_outstanding_o (wr_outstanding)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // model: transactions in flight, acks owed, address shown but not taken
  int m_rd_out, m_rd_pend, m_wr_out, m_wr_pend;
  bit m_rd_pres, m_wr_pres;
  bit m_flushing, m_quiet;

  // values seen at the last checked cycle
  bit snap_rack, snap_wack, snap_ar_valid, snap_aw_valid, snap_flush_done;
  int snap_rd_out, snap_wr_out;
  bit snap_ar_acc, snap_aw_acc;

  task automatic checkValue(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic resetModel();
    m_rd_out = 0; m_rd_pend = 0; m_wr_out = 0; m_wr_pend = 0;
    m_rd_pres = 0; m_wr_pres = 0; m_flushing = 0; m_quiet = 0;
    snap_ar_acc = 0; snap_aw_acc = 0;
  endtask

  task automatic applyStimulus(input bit ar_v, input bit ar_rdy, input bit aw_v, input bit aw_rdy,
                               input bit r_v, input bit r_rdy, input bit r_l,
                               input bit b_v, input bit b_rdy,
                               input bit r_hold, input bit w_hold, input bit fl);
    slv_if.req.aw_id    = id_t'($urandom);
    slv_if.req.aw_addr  = addr_t'($urandom);
    slv_if.req.aw_len   = 8'($urandom);
    slv_if.req.aw_atop  = '0;
    slv_if.req.aw_valid = aw_v;
    slv_if.req.w_data   = data_t'($urandom);
    slv_if.req.w_strb   = strb_t'($urandom);
    slv_if.req.w_last   = 1'($urandom);
    slv_if.req.w_valid  = 1'($urandom);
    slv_if.req.b_ready  = b_rdy;
    slv_if.req.ar_id    = id_t'($urandom);
    slv_if.req.ar_addr  = addr_t'($urandom);
    slv_if.req.ar_len   = 8'($urandom);
    slv_if.req.ar_valid = ar_v;
    slv_if.req.r_ready  = r_rdy;
    slv_if.req.wack     = 1'($urandom);
    slv_if.req.rack     = 1'($urandom);
    mst_if.resp.aw_ready = aw_rdy;
    mst_if.resp.ar_ready = ar_rdy;
    mst_if.resp.w_ready  = 1'($urandom);
    mst_if.resp.b_id     = id_t'($urandom);
    mst_if.resp.b_resp   = 2'($urandom);
    mst_if.resp.b_valid  = b_v;
    mst_if.resp.r_id     = id_t'($urandom);
    mst_if.resp.r_data   = data_t'($urandom);
    mst_if.resp.r_resp   = 4'($urandom);
    mst_if.resp.r_last   = r_l;
    mst_if.resp.r_valid  = r_v;
    rack_hold = r_hold;
    wack_hold = w_hold;
    flush     = fl;
  endtask

  // Compare every output against the model at mid-cycle, then advance the model.
  task automatic checkOutput();
    ace_req_t  exp_req;
    ace_resp_t exp_resp;
    bit rd_open, wr_open, exp_rack, exp_wack, ar_hs, aw_hs, r_fin, b_fin;
    @(negedge clk);
    rd_open  = m_rd_pres || (m_rd_out < int'(MaxRd) && !m_flushing && !m_quiet);
    wr_open  = m_wr_pres || (m_wr_out < int'(MaxWr) && !m_flushing && !m_quiet);
    exp_rack = (m_rd_pend > 0) && !rack_hold;
    exp_wack = (m_wr_pend > 0) && !wack_hold;
    exp_req  = slv_if.req;
    exp_req.ar_valid = slv_if.req.ar_valid && rd_open;
    exp_req.aw_valid = slv_if.req.aw_valid && wr_open;
    exp_req.rack     = exp_rack;
    exp_req.wack     = exp_wack;
    exp_resp = mst_if.resp;
    exp_resp.ar_ready = mst_if.resp.ar_ready && rd_open;
    exp_resp.aw_ready = mst_if.resp.aw_ready && wr_open;
    checkValue("mst_req", 256'(mst_if.req), 256'(exp_req));
    checkValue("slv_resp", 256'(slv_if.resp), 256'(exp_resp));
    checkValue("rd_outstanding", 256'(rd_outstanding), 256'(m_rd_out));
    checkValue("wr_outstanding", 256'(wr_outstanding), 256'(m_wr_out));
    checkValue("flush_done", 256'(flush_done), 256'(m_quiet));
    snap_rack = mst_if.req.rack;         snap_wack = mst_if.req.wack;
    snap_ar_valid = mst_if.req.ar_valid; snap_aw_valid = mst_if.req.aw_valid;
    snap_flush_done = flush_done;
    snap_rd_out = int'(rd_outstanding); snap_wr_out = int'(wr_outstanding);
    snap_ar_acc = slv_if.req.ar_valid && slv_if.resp.ar_ready;
    snap_aw_acc = slv_if.req.aw_valid && slv_if.resp.aw_ready;
    ar_hs = exp_req.ar_valid && mst_if.resp.ar_ready;
    aw_hs = exp_req.aw_valid && mst_if.resp.aw_ready;
    r_fin = mst_if.resp.r_valid && slv_if.req.r_ready && mst_if.resp.r_last;
    b_fin = mst_if.resp.b_valid && slv_if.req.b_ready;
    m_rd_out  += int'(ar_hs) - int'(exp_rack);
    m_rd_pend += int'(r_fin) - int'(exp_rack);
    m_wr_out  += int'(aw_hs) - int'(exp_wack);
    m_wr_pend += int'(b_fin) - int'(exp_wack);
    m_rd_pres = exp_req.ar_valid && !mst_if.resp.ar_ready;
    m_wr_pres = exp_req.aw_valid && !mst_if.resp.aw_ready;
    if (m_quiet) begin
      if (!flush) m_quiet = 0;
    end else if (m_flushing) begin
      if (!flush) m_flushing = 0;
      else if (m_rd_out == 0 && m_wr_out == 0 && !m_rd_pres && !m_wr_pres) begin
        m_flushing = 0;
        m_quiet    = 1;
      end
    end else if (flush) begin
      m_flushing = 1;
    end
    @(posedge clk);
    #1;
  endtask

  // Retire everything in flight and leave the flush state.
  task automatic drainAll();
    for (int i = 0; i < 40; i++) begin
      if (m_rd_out == 0 && m_wr_out == 0 && !m_rd_pres && !m_wr_pres && !m_flushing && !m_quiet) break;
      applyStimulus(m_rd_pres, 1, m_wr_pres, 1, 1, 1, m_rd_out > m_rd_pend,
                    m_wr_out > m_wr_pend, 1, 0, 0, 0);
      checkOutput();
    end
  endtask

  initial begin
    bit ar_v, aw_v, ar_rdy, aw_rdy, r_v, r_rdy, r_l, b_v, b_rdy, rh, wh, fl;
    rst = 1'b1;
    applyStimulus(0,0,0,0, 0,0,0, 0,0, 0,0,0);
    resetModel();
    repeat (2) @(posedge clk);
    #1;
    checkValue("reset_rd_out", 256'(rd_outstanding), 256'(0));
    checkValue("reset_wr_out", 256'(wr_outstanding), 256'(0));
    checkValue("reset_flush_done", 256'(flush_done), 256'(0));
    checkValue("reset_rack", 256'(mst_if.req.rack), 256'(0));
    checkValue("reset_wack", 256'(mst_if.req.wack), 256'(0));
    rst = 1'b0;

    // single read, four beats, last in cycle t
    applyStimulus(1,1,0,0, 0,0,0, 0,0, 0,0,0); checkOutput();
    checkValue("rd1_ar_valid", 256'(snap_ar_valid), 256'(1));
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0,0,0,0, 1,1,0, 0,0, 0,0,0); checkOutput();
    end
    checkValue("rd1_out_beats", 256'(snap_rd_out), 256'(1));
    applyStimulus(0,0,0,0, 1,1,1, 0,0, 0,0,0); checkOutput();
    checkValue("rd1_rack_t", 256'(snap_rack), 256'(0));
    applyStimulus(0,0,0,0, 0,0,0, 0,0, 0,0,0); checkOutput();
    checkValue("rd1_rack_t1", 256'(snap_rack), 256'(1));
    checkValue("rd1_out_t1", 256'(snap_rd_out), 256'(1));
    applyStimulus(0,0,0,0, 0,0,0, 0,0, 0,0,0); checkOutput();
    checkValue("rd1_rack_t2", 256'(snap_rack), 256'(0));
    checkValue("rd1_out_t2", 256'(snap_rd_out), 256'(0));

    // read limit of two
    applyStimulus(1,1,0,0, 0,0,0, 0,0, 0,0,0); checkOutput();
    applyStimulus(1,1,0,0, 0,0,0, 0,0, 0,0,0); checkOutput();
    applyStimulus(1,1,0,0, 0,0,0, 0,0, 0,0,0); checkOutput();
    checkValue("lim_third_blocked", 256'(snap_ar_valid), 256'(0));
    checkValue("lim_out_full", 256'(snap_rd_out), 256'(2));
    applyStimulus(1,1,0,0, 1,1,1, 0,0, 0,0,0); checkOutput();
    applyStimulus(1,1,0,0, 0,0,0, 0,0, 0,0,0); checkOutput();
    checkValue("lim_rack", 256'(snap_rack), 256'(1));
    checkValue("lim_ack_cycle_blocked", 256'(snap_ar_valid), 256'(0));
    applyStimulus(1,1,0,0, 0,0,0, 0,0, 0,0,0); checkOutput();
    checkValue("lim_third_presented", 256'(snap_ar_valid), 256'(1));
    drainAll();

    // WACK hold
    applyStimulus(0,0,1,1, 0,0,0, 0,0, 0,0,0); checkOutput();
    applyStimulus(0,0,1,1, 0,0,0, 0,0, 0,0,0); checkOutput();
    applyStimulus(0,0,0,0, 0,0,0, 1,1, 0,0,0); checkOutput();
    checkValue("hold_wack_t", 256'(snap_wack), 256'(0));
    applyStimulus(0,0,0,0, 0,0,0, 1,1, 0,1,0); checkOutput();
    checkValue("hold_wack_t1", 256'(snap_wack), 256'(0));
    applyStimulus(0,0,0,0, 0,0,0, 0,0, 0,1,0); checkOutput();
    applyStimulus(0,0,0,0, 0,0,0, 0,0, 0,1,0); checkOutput();
    checkValue("hold_wack_t3", 256'(snap_wack), 256'(0));
    applyStimulus(0,0,0,0, 0,0,0, 0,0, 0,0,0); checkOutput();
    checkValue("hold_wack_t4", 256'(snap_wack), 256'(1));
    applyStimulus(0,0,0,0, 0,0,0, 0,0, 0,0,0); checkOutput();
    checkValue("hold_wack_t5", 256'(snap_wack), 256'(1));
    applyStimulus(0,0,0,0, 0,0,0, 0,0, 0,0,0); checkOutput();
    checkValue("hold_wack_t6", 256'(snap_wack), 256'(0));
    checkValue("hold_wr_out_t6", 256'(snap_wr_out), 256'(0));

    // valid stability across flush
    applyStimulus(1,0,0,0, 0,0,0, 0,0, 0,0,0); checkOutput();
    applyStimulus(1,0,0,0, 0,0,0, 0,0, 0,0,1); checkOutput();
    applyStimulus(1,0,0,0, 0,0,0, 0,0, 0,0,1); checkOutput();
    checkValue("stab_valid_in_drain", 256'(snap_ar_valid), 256'(1));
    applyStimulus(1,1,0,0, 0,0,0, 0,0, 0,0,1); checkOutput();
    checkValue("stab_handshake", 256'(snap_ar_valid), 256'(1));
    applyStimulus(0,0,0,0, 1,1,1, 0,0, 0,0,1); checkOutput();
    applyStimulus(0,0,0,0, 0,0,0, 0,0, 0,0,1); checkOutput();
    checkValue("stab_rack", 256'(snap_rack), 256'(1));
    checkValue("stab_not_done_yet", 256'(snap_flush_done), 256'(0));
    applyStimulus(1,1,0,0, 0,0,0, 0,0, 0,0,1); checkOutput();
    checkValue("stab_flush_done", 256'(snap_flush_done), 256'(1));
    checkValue("stab_done_blocks_ar", 256'(snap_ar_valid), 256'(0));
    applyStimulus(1,1,0,0, 0,0,0, 0,0, 0,0,0); checkOutput();
    checkValue("stab_done_until_drop", 256'(snap_flush_done), 256'(1));
    applyStimulus(1,1,0,0, 0,0,0, 0,0, 0,0,0); checkOutput();
    checkValue("stab_run_accepts", 256'(snap_ar_valid), 256'(1));
    drainAll();

    // flush with two writes in flight
    applyStimulus(0,0,1,1, 0,0,0, 0,0, 0,0,0); checkOutput();
    applyStimulus(0,0,1,1, 0,0,0, 0,0, 0,0,0); checkOutput();
    applyStimulus(0,0,0,0, 0,0,0, 0,0, 0,0,1); checkOutput();
    applyStimulus(0,0,1,1, 0,0,0, 0,0, 0,0,1); checkOutput();
    checkValue("fl_aw_blocked", 256'(snap_aw_valid), 256'(0));
    applyStimulus(0,0,1,1, 0,0,0, 1,1, 0,0,1); checkOutput();
    applyStimulus(0,0,1,1, 0,0,0, 1,1, 0,0,1); checkOutput();
    applyStimulus(0,0,1,1, 0,0,0, 0,0, 0,0,1); checkOutput();
    checkValue("fl_second_wack", 256'(snap_wack), 256'(1));
    checkValue("fl_not_done", 256'(snap_flush_done), 256'(0));
    applyStimulus(0,0,1,1, 0,0,0, 0,0, 0,0,1); checkOutput();
    checkValue("fl_done", 256'(snap_flush_done), 256'(1));
    checkValue("fl_done_aw_blocked", 256'(snap_aw_valid), 256'(0));
    applyStimulus(0,0,1,1, 0,0,0, 0,0, 0,0,0); checkOutput();
    applyStimulus(0,0,1,1, 0,0,0, 0,0, 0,0,0); checkOutput();
    checkValue("fl_run_aw_accepted", 256'(snap_aw_valid), 256'(1));
    drainAll();

    // asynchronous reset with traffic in flight
    applyStimulus(1,1,0,0, 0,0,0, 0,0, 0,0,0); checkOutput();
    applyStimulus(1,1,0,0, 0,0,0, 0,0, 0,0,0); checkOutput();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0,0,1,1, 0,0,0, 0,0, 0,0,0); checkOutput();
    end
    applyStimulus(0,0,0,0, 1,1,1, 0,0, 0,0,0); checkOutput();
    applyStimulus(0,0,0,0, 0,0,0, 0,0, 0,0,0);
    #1;
    checkValue("rst_pre_rack", 256'(mst_if.req.rack), 256'(1));
    checkValue("rst_pre_wr_out", 256'(wr_outstanding), 256'(3));
    rst = 1'b1;
    #1;
    checkValue("rst_rd_out", 256'(rd_outstanding), 256'(0));
    checkValue("rst_wr_out", 256'(wr_outstanding), 256'(0));
    checkValue("rst_rack", 256'(mst_if.req.rack), 256'(0));
    checkValue("rst_flush_done", 256'(flush_done), 256'(0));
    resetModel();
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1,1,0,0, 0,0,0, 0,0, 0,0,0); checkOutput();
    checkValue("rst_after_ar", 256'(snap_ar_valid), 256'(1));
    checkValue("rst_after_out", 256'(snap_rd_out), 256'(0));
    drainAll();

    // randomized traffic
    fl = 0;
    for (int c = 0; c < 3000; c++) begin
      ar_v = (slv_if.req.ar_valid && !snap_ar_acc) ? 1'b1 : ($urandom_range(0, 2) == 0);
      aw_v = (slv_if.req.aw_valid && !snap_aw_acc) ? 1'b1 : ($urandom_range(0, 2) == 0);
      ar_rdy = 1'($urandom); aw_rdy = 1'($urandom);
      r_v = 1'($urandom); r_rdy = 1'($urandom); r_l = 1'($urandom);
      b_v = 1'($urandom); b_rdy = 1'($urandom);
      if (r_v && r_rdy && r_l && !(m_rd_out > m_rd_pend)) r_l = 0;
      if (b_v && b_rdy && !(m_wr_out > m_wr_pend)) b_v = 0;
      rh = ($urandom_range(0, 3) == 0);
      wh = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 29) == 0) fl = !fl;
      applyStimulus(ar_v, ar_rdy, aw_v, aw_rdy, r_v, r_rdy, r_l, b_v, b_rdy, rh, wh, fl);
      checkOutput();
    end
    drainAll();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
